// File: rtl/sram_rw0_ctrl.sv
// rtl/sram_rw0_ctrl.sv - valid/ready front end for a single-port RW0 SRAM macro with 2-entry read response buffer
// Optional post-reset zero-fill sweep enabled by defining SRAM_CTRL_INIT_EN.
module sram_rw0_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    logic run;
    logic fire;

`ifdef SRAM_CTRL_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] init_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_INIT && init_cnt == LAST_ADDR) begin
            state_next = ST_RUN;
        end
    end

    assign run  = (state == ST_RUN);
    assign busy = (state == ST_INIT);
`else
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    // Response buffer: two entries plus the read currently on RW0_rdata.
    logic [DATA_W-1:0] fifo_mem [2];
    logic              head;
    logic              tail;
    logic [1:0]        cnt;
    logic              inflight;
    logic [2:0]        occupancy;
    logic              buf_empty;
    logic              push;
    logic              pop;

    assign occupancy = {1'b0, cnt} + {2'b00, inflight};
    assign buf_empty = (cnt == 2'd0);

    // Credit uses registered state only, never resp_ready.
    assign req_ready = run && (req_write || occupancy < 3'd2);
    assign fire      = req_valid && req_ready;

    assign resp_valid = !buf_empty || inflight;
    assign resp_rdata = buf_empty ? RW0_rdata : fifo_mem[head];

    // Bypassed data is parked only if the consumer does not take it this cycle.
    assign push = inflight && !(buf_empty && resp_ready);
    assign pop  = !buf_empty && resp_ready;

    always_comb begin
        RW0_en    = fire;
        RW0_wmode = req_write;
        RW0_addr  = req_addr;
        RW0_wmask = req_wmask;
        RW0_wdata = req_wdata;
`ifdef SRAM_CTRL_INIT_EN
        if (!run) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = init_cnt;
            RW0_wmask = '1;
            RW0_wdata = '0;
        end
`endif
        if (reset) begin
            RW0_en = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= fire && !req_write;
            if (push) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[tail] <= RW0_rdata;
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            assert (occupancy <= 3'd2);
        end
    end

endmodule

// File: tb/tb_sram_rw0_ctrl.sv
// tb/tb_sram_rw0_ctrl.sv - self-checking bench for sram_rw0_ctrl with a behavioral RW0 macro
module tb_sram_rw0_ctrl;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [MW-1:0] req_wmask = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [DW-1:0] resp_rdata;
    logic          busy;
    logic [AW-1:0] RW0_addr;
    logic          RW0_en;
    logic          RW0_wmode;
    logic [MW-1:0] RW0_wmask;
    logic [DW-1:0] RW0_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    sram_rw0_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
        .clock      (clk),
        .reset      (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .RW0_addr   (RW0_addr),
        .RW0_en     (RW0_en),
        .RW0_wmode  (RW0_wmode),
        .RW0_wmask  (RW0_wmask),
        .RW0_wdata  (RW0_wdata),
        .RW0_rdata  (mem_rdata)
    );

    // Behavioral macro: masked byte writes, registered one-cycle read.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                for (int g = 0; g < MW; g++) begin
                    if (RW0_wmask[g]) mem[RW0_addr][g*8 +: 8] <= RW0_wdata[g*8 +: 8];
                end
            end else begin
                mem_rdata <= mem[RW0_addr];
            end
        end
    end

    int            nerr = 0;
    int            nchk = 0;
    logic [DW-1:0] expq [$];
    logic [DW-1:0] cur_exp = '0;
    bit            prev_rd = 1'b0;

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [MW-1:0] m;
        logic [DW-1:0] d;
        logic [DW-1:0] e;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle: sample just before the rising edge, then return at the next falling edge.
    task automatic step(output bit fired);
        #4;
        if (prev_rd) chk("read_latency_valid", 64'(resp_valid), 64'd1);
        fired   = req_valid && req_ready;
        prev_rd = fired && !req_write;
        if (prev_rd) expq.push_back(cur_exp);
        if (resp_valid && resp_ready) begin
            if (expq.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'd0);
            else chk("resp_rdata", resp_rdata, expq.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [MW-1:0] m,
                         input logic [DW-1:0] d, input logic [DW-1:0] e);
        bit f;
        int n;
        f = 1'b0;
        n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wmask = m; req_wdata = d; cur_exp = e;
        while (!f && n < 50) begin
            step(f);
            n++;
        end
        if (!f) chk("issue_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit f;
        int n;
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            step(f);
            n++;
        end
        chk("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    task automatic post_reset();
`ifdef SRAM_CTRL_INIT_EN
        int i;
        i = 0;
        while (i < 100) begin
            #4;
            if (!busy) break;
            chk("init_ctl", {54'd0, RW0_en, RW0_wmode, req_ready, RW0_wmask[6:0]}, {54'd0, 3'b110, 7'h7F});
            chk("init_addr_data", {RW0_wdata[59:0], RW0_addr}, {60'd0, 4'(i)});
            @(posedge clk);
            @(negedge clk);
            i++;
        end
        chk("init_cycles", 64'(i), 64'd16);
        chk("init_done_ready", 64'(req_ready), 64'd1);
`else
        #4;
        chk("noinit_busy", 64'(busy), 64'd0);
        chk("noinit_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
`endif
    endtask

    initial begin
        bit f;

        tbl[0]  = '{1'b1, 4'd3, 8'hFF, 64'hA5A5_0000_0000_0001, 64'd0};
        tbl[1]  = '{1'b1, 4'd7, 8'hFF, 64'hDEAD_BEEF_0000_0002, 64'd0};
        tbl[2]  = '{1'b0, 4'd3, 8'h00, 64'd0, 64'hA5A5_0000_0000_0001};
        tbl[3]  = '{1'b0, 4'd7, 8'h00, 64'd0, 64'hDEAD_BEEF_0000_0002};
        tbl[4]  = '{1'b1, 4'd5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        tbl[5]  = '{1'b1, 4'd5, 8'h01, 64'd0, 64'd0};
        tbl[6]  = '{1'b0, 4'd5, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FF00};
        tbl[7]  = '{1'b1, 4'd9, 8'hFF, 64'h11, 64'd0};
        tbl[8]  = '{1'b0, 4'd9, 8'h00, 64'd0, 64'h11};
        tbl[9]  = '{1'b1, 4'd9, 8'hFF, 64'h22, 64'd0};
        tbl[10] = '{1'b0, 4'd9, 8'h00, 64'd0, 64'h22};

        #2;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rw0_en", 64'(RW0_en), 64'd0);
`ifdef SRAM_CTRL_INIT_EN
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
`else
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
`endif
        @(negedge clk);
        rst = 1'b0;
        post_reset();

`ifdef SRAM_CTRL_INIT_EN
        resp_ready = 1'b1;
        for (int a = 0; a < 16; a++) issue(1'b0, 4'(a), 8'h00, 64'd0, 64'd0);
        drain();
`endif

        resp_ready = 1'b1;
        for (int i = 0; i < 11; i++) issue(tbl[i].w, tbl[i].a, tbl[i].m, tbl[i].d, tbl[i].e);
        drain();

        // Backpressure: two reads absorbed, third stalls until the cycle after the first pop.
        resp_ready = 1'b0;
        issue(1'b0, 4'd3, 8'h00, 64'd0, 64'hA5A5_0000_0000_0001);
        issue(1'b0, 4'd7, 8'h00, 64'd0, 64'hDEAD_BEEF_0000_0002);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5; cur_exp = 64'hFFFF_FFFF_FFFF_FF00;
        for (int k = 0; k < 3; k++) begin
            step(f);
            chk("bp_stall", 64'(f), 64'd0);
            chk("bp_head_stable", resp_rdata, 64'hA5A5_0000_0000_0001);
            chk("bp_valid_held", 64'(resp_valid), 64'd1);
        end
        resp_ready = 1'b1;
        step(f);
        chk("bp_no_fire_on_pop", 64'(f), 64'd0);
        step(f);
        chk("bp_resume", 64'(f), 64'd1);
        req_valid = 1'b0;
        drain();

        // Reset with two responses buffered.
        resp_ready = 1'b0;
        issue(1'b0, 4'd9, 8'h00, 64'd0, 64'h22);
        issue(1'b0, 4'd3, 8'h00, 64'd0, 64'hA5A5_0000_0000_0001);
        step(f);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_rw0_en", 64'(RW0_en), 64'd0);
        expq.delete();
        prev_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        post_reset();
        resp_ready = 1'b1;
`ifdef SRAM_CTRL_INIT_EN
        issue(1'b0, 4'd3, 8'h00, 64'd0, 64'd0);
`else
        issue(1'b0, 4'd3, 8'h00, 64'd0, 64'hA5A5_0000_0000_0001);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sram_rw0_ctrl.md
# sram_rw0_ctrl

Request/response controller that drives the single-port RW0 interface of a behavioral or hard SRAM macro. It converts a valid/ready request stream into RW0 port cycles and absorbs the macro's one-cycle read latency with a 2-entry response buffer and registered backpressure. It sits between an agent (cache pipeline, DMA, test harness) and one `*_ext` RW0 memory instance. Optionally, it zero-fills the array after reset.

## Interface
Parameters:
- ADDR_W, 9, RW0 address width; DEPTH = 2**ADDR_W
- DATA_W, 64, data width
- MASK_W, 8, write-mask width; DATA_W % MASK_W == 0, mask granule = DATA_W/MASK_W bits

Ports:
- clock  in  1  single clock; also tied to the macro's RW0_clk by the parent
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid && ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wmask  in  MASK_W  per-granule write enable (ignored on reads)
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data present
- resp_ready  in  1  consumer takes data when valid && ready
- resp_rdata  out  DATA_W  read data, in request order
- busy  out  1  init sweep in progress
- RW0_addr  out  ADDR_W  to macro
- RW0_en  out  1  to macro
- RW0_wmode  out  1  to macro
- RW0_wmask  out  MASK_W  to macro
- RW0_wdata  out  DATA_W  to macro
- RW0_rdata  in  DATA_W  from macro; valid the cycle after a read enable

## Operation
**State machine: INIT, RUN.**
- Reset enters INIT when SRAM_CTRL_INIT_EN is defined, else RUN.
- INIT: a counter sweeps 0..DEPTH-1, one write per cycle: RW0_en=1, RW0_wmode=1, wmask all ones, wdata 0; busy=1, req_ready=0. After the write to DEPTH-1, the FSM goes to RUN. The counter wraps to 0 and is not reused.
- RUN:
  - fire = req_valid && req_ready
  - RW0_en = fire; RW0_wmode = req_write; addr/wmask/wdata pass through combinationally.
- Writes produce no response.
- Reads:
  - A read fire sets the `inflight` flag for the next cycle.
  - In that cycle RW0_rdata is either bypassed to resp_* (buffer empty) or pushed into the 2-entry FIFO.
  - If bypassed and not taken (resp_ready=0), the data is pushed.
- Response outputs:
  - resp_valid = (cnt != 0) || inflight
  - resp_rdata = cnt != 0 ? FIFO head : RW0_rdata
  - Bypass never overtakes buffered entries.
- Credit: req_ready = RUN && (req_write || cnt + inflight < 2).
  - Writes are always accepted in RUN.
  - req_ready depends only on registered state, req_write, and RUN; there is no path from resp_ready.
- Ordering: responses return in read-issue order.
- Read-after-write: a write to the same address in the cycle after a read returns the pre-write value, because it is sampled that cycle.
- Invariant: cnt + inflight <= 2; overflow is impossible and is asserted in simulation.

## Timing
- Reset values: req_ready=0 in INIT, 1 in RUN; resp_valid=0; RW0_en=0; busy=1 in INIT, 0 in RUN; cnt=0; inflight=0; init counter 0.
- Read latency: accepted at cycle N, resp_valid at N+1 (bypass).
- Throughput: one read per cycle sustained with resp_ready=1.
- With resp_ready=0: two reads accepted, then req_ready=0 for reads. Reads resume the cycle after the first pop.
- Simultaneous push and pop: cnt unchanged; head advances.
- Init duration: exactly DEPTH cycles after reset deassertion; the first request can be accepted at cycle DEPTH.
- Reset asserted mid-operation or mid-init:
  - Immediately clears FIFO, inflight, and counter; forces RW0_en=0.
  - INIT restarts from address 0.
  - In-flight reads are dropped.

## Configuration
- SRAM_CTRL_INIT_EN defined: the INIT state and sweep counter exist, and the macro is zeroed after every reset.
- Undefined: no INIT logic; reset enters RUN; busy is tied 0; req_ready=1 from the first cycle after reset; memory contents are whatever the macro holds (random under RANDOMIZE_MEM_INIT).

## Test plan
- Init (macro defined, ADDR_W=4): release reset → busy=1 for 16 cycles, 16 writes of 0 with wmask=8'hFF to addresses 0..15, then busy=0 and req_ready=1; reads of all addresses return 0.
- Back-to-back: write 0xA5A5_0000_0000_0001 to addr 3 and 0xDEAD_BEEF_0000_0002 to addr 7, then read 3 and 7 on consecutive cycles with resp_ready=1 → responses at N+1 and N+2 with matching data, in order.
- Backpressure: resp_ready=0, issue 3 reads → only 2 accepted, resp_valid held with the first data stable. Raise resp_ready → the third read is accepted the cycle after the first pop; all 3 return in order.
- Partial mask: write all ones to addr 5, then write 0 with wmask=8'b0000_0001 → read returns 0xFFFF_FFFF_FFFF_FF00.
- Read-then-write same address: addr 9 holds 0x11; read 9 at N, write 0x22 at N+1 → response 0x11; a subsequent read returns 0x22.
- Reset mid-operation: assert reset with 2 responses buffered → resp_valid=0 immediately. After release, with the init macro defined, the sweep restarts at address 0.
